// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch-priority grant into a 2-entry in-order pipe, 1 cycle accept->response, ready drops when s2 is held and s1 full.
// Define IMEM_ARB_STARVE_EN to force the secondary port through after STARVE_MAX consecutive lost arbitrations.
module imem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef IMEM_ARB_STARVE_EN
    ,
    parameter int STARVE_MAX = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_valid_i,
    output logic          f_ready_o,
    input  logic [AW-1:0] f_addr_i,
    output logic          f_valid_ro,
    input  logic          f_ready_i,
    output logic [DW-1:0] f_data_ro,
    input  logic          flush_i,
    input  logic          d_valid_i,
    output logic          d_ready_o,
    input  logic [AW-1:0] d_addr_i,
    input  logic          d_we_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_valid_ro,
    input  logic          d_ready_i,
    output logic [DW-1:0] d_rdata_ro,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    logic          s1_v_q, s1_v_d;
    owner_e        s1_own_q, s1_own_d;
    logic          s1_we_q, s1_we_d;
    logic          s2_v_q, s2_v_d;
    owner_e        s2_own_q, s2_own_d;
    logic [DW-1:0] s2_data_q, s2_data_d;

    logic drain2;
    logic adv1;
    logic move12;
    logic starve_force;
    logic grant_f;
    logic grant_d;

`ifdef IMEM_ARB_STARVE_EN
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = d_valid_i && (starve_cnt_q == CW'(STARVE_MAX));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_d || !d_valid_i) begin
            starve_cnt_d = '0;
        end else if (grant_f && (starve_cnt_q != CW'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    always_comb begin
        drain2  = s2_v_q && ((s2_own_q == OWN_F) ? f_ready_i : d_ready_i);
        adv1    = !s1_v_q || !s2_v_q || drain2;
        move12  = s1_v_q && (!s2_v_q || drain2);
        // Grants are gated by reset so the memory never sees a strobe while held in reset.
        grant_f = rst && adv1 && f_valid_i && !flush_i && !starve_force;
        grant_d = rst && adv1 && d_valid_i && !grant_f;
    end

    assign f_ready_o   = grant_f;
    assign d_ready_o   = grant_d;
    assign mem_en_o    = grant_f || grant_d;
    assign mem_we_o    = grant_d && d_we_i;
    assign mem_addr_o  = grant_f ? f_addr_i : d_addr_i;
    assign mem_wdata_o = grant_d ? d_wdata_i : '0;

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_own_d  = s1_own_q;
        s1_we_d   = s1_we_q;
        s2_v_d    = s2_v_q;
        s2_own_d  = s2_own_q;
        s2_data_d = s2_data_q;

        if (move12) begin
            s2_v_d    = 1'b1;
            s2_own_d  = s1_own_q;
            s2_data_d = s1_we_q ? '0 : mem_rdata_i;
        end else if (drain2) begin
            s2_v_d = 1'b0;
        end

        if (grant_f || grant_d) begin
            s1_v_d   = 1'b1;
            s1_own_d = grant_f ? OWN_F : OWN_D;
            s1_we_d  = grant_d && d_we_i;
        end else if (move12) begin
            s1_v_d = 1'b0;
        end

        // Flush applies after the move so a fetch entry shifting into s2 is also killed.
        if (flush_i) begin
            if (s1_own_d == OWN_F) s1_v_d = 1'b0;
            if (s2_own_d == OWN_F) s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_v_q    <= 1'b0;
            s1_own_q  <= OWN_F;
            s1_we_q   <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_own_q  <= OWN_F;
            s2_data_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_own_q  <= s1_own_d;
            s1_we_q   <= s1_we_d;
            s2_v_q    <= s2_v_d;
            s2_own_q  <= s2_own_d;
            s2_data_q <= s2_data_d;
        end
    end

    assign f_valid_ro = s2_v_q && (s2_own_q == OWN_F);
    assign d_valid_ro = s2_v_q && (s2_own_q == OWN_D);
    assign f_data_ro  = s2_data_q;
    assign d_rdata_ro = s2_data_q;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port instruction memory between the fetch path (insm request side) and a secondary data/loader requester, with valid/ready handshakes on both sides. Fetch has priority, an optional starvation guard protects the secondary port, and a two-entry in-order pipeline sustains one access per cycle. Fetch-owned entries are killed on branch redirect. The block sits between insm/loader and the synchronous instruction ROM/RAM.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive lost arbitrations before the secondary port is forced through (guard builds only)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- f_valid_i / f_ready_o  in/out  1  fetch request handshake
- f_addr_i  in  AW  fetch address
- f_valid_ro / f_ready_i  out/in  1  fetch response handshake
- f_data_ro  out  DW  fetch read data
- flush_i  in  1  branch taken; kills fetch-owned work
- d_valid_i / d_ready_o  in/out  1  secondary request handshake
- d_addr_i  in  AW  secondary address
- d_we_i  in  1  secondary write
- d_wdata_i  in  DW  write data
- d_valid_ro / d_ready_i  out/in  1  secondary response handshake
- d_rdata_ro  out  DW  read data; 0 for write acks
- mem_en_o, mem_we_o  out  1  memory strobe, write enable
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  data registered by memory at the edge after mem_en_o; memory holds it while mem_en_o=0

## Operation
- Pipeline entries:
  - s1 (issued, data arriving): s1_v, s1_own.
  - s2 (response register): s2_v, s2_own, s2_data.
- Advancement:
  - adv1 = !s1_v | !s2_v | drain2.
  - drain2 = s2_v & owner's ready_i.
- Grant, combinational. Only when adv1:
  - Fetch wins if f_valid_i & !flush_i.
  - Otherwise the secondary port wins if d_valid_i.
  - Guard override: the secondary port wins when counter==STARVE_MAX and d_valid_i.
- Ready outputs:
  - f_ready_o = grant_f.
  - d_ready_o = grant_d.
- mem_en_o = grant_f | grant_d. mem_addr_o, mem_we_o, mem_wdata_o are muxed from the winner. mem_we_o is only possible for the secondary port.
- At each edge:
  - If s1_v and s2 is free or draining, s1 moves to s2 and s2_data captures mem_rdata_i (forced to 0 for writes).
  - A granted request fills s1.
  - Each request yields exactly one response, in order.
- f_valid_ro = s2_v & s2_own==F. d_valid_ro = s2_v & s2_own==D. Both are registered.
- Flush: when flush_i=1 at an edge, fetch-owned s1/s2 entries are invalidated after any move. Secondary entries are untouched. No fetch grant occurs in the flush cycle.
- Width: addresses pass through unmodified. There is no alignment check.

## Timing
- Reset (rst=0 at an edge):
  - s1_v=s2_v=0, counter=0.
  - f_valid_ro=d_valid_ro=0; f_data_ro=d_rdata_ro=0.
  - mem_en_o=mem_we_o=0, because grants are gated by rst=0.
  - In-flight entries are dropped with no response.
- Latency: request accepted at edge N gives valid_ro high from edge N+1, with data visible that cycle.
- Throughput: one access per cycle while responses drain.
- Back-pressure: s2 held and s1 full makes adv1=0, so both ready outputs drop. The memory output is held because mem_en_o=0.
- A response transfer in the same cycle as flush_i completes its handshake. The consumer discards it.
- flush_i and f_valid_i together: request not accepted. A secondary request may be granted that cycle.

## Configuration
- IMEM_ARB_STARVE_EN defined:
  - A saturating counter increments each cycle that d_valid_i=1 and fetch is granted.
  - It resets to 0 on a secondary grant or when d_valid_i=0.
  - At STARVE_MAX the secondary request wins the next grant.
- Undefined: strict fetch priority, no counter logic. The secondary port may starve indefinitely.

## Test plan
- Reset then stream: f_valid_i=1 at addrs 0,4,8; ROM word=addr → f_data_ro 0,4,8 on consecutive cycles, one edge after each accept.
- Contention: f_valid_i and d_valid_i (read 0x100) held for 6 cycles:
  - With IMEM_ARB_STARVE_EN: 4 fetch grants, then the secondary is granted on the 5th → d_rdata_ro=0x100.
  - Without the macro: no secondary grant.
- Flush: fetch at 0x10 and 0x14 in flight, flush_i pulse → no fetch response for either. A fetch to 0x28 issued the next cycle returns 0x28.
- Back-pressure: f_ready_i=0 for 3 cycles with 2 issued → f_ready_o=0 and the held f_data_ro is stable. Release → both responses delivered in order, none lost.
- Write then read: d_we_i=1, addr 0x40, data 0xDEADBEEF → ack with d_rdata_ro=0. Following read of 0x40 → 0xDEADBEEF.
- Reset mid-stream: rst=0 for 1 edge with s1 and s2 full → all valid outputs 0 next cycle, counter 0, no stale response afterwards.
